// File: rtl/crack_ctrl.sv
// Key-search sequencer: steps one arc4 core through a key range and stops at the
// first key whose snooped plaintext is entirely printable ASCII.
module crack_ctrl #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'd1,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        a4_en,
  input  logic        a4_rdy,
  output logic [23:0] a4_key,
  input  logic        pt_wren,
  input  logic [7:0]  pt_addr,
  input  logic [7:0]  pt_wrdata
);

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PRINT_LO = 8'h20;
  localparam logic [BYTE_W-1:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t            state;
  logic [BYTE_W-1:0] len;
  logic              len_seen;
  logic              bad;

  logic snoop_c;
  logic printable_c;
  logic pass_c;
  logic last_key_c;

  // Snoop qualification and end-of-key decisions.
  always_comb begin
    snoop_c     = pt_wren && ((state == LAUNCH) || (state == RUN));
    printable_c = (pt_wrdata >= PRINT_LO) && (pt_wrdata <= PRINT_HI);
    pass_c      = len_seen && !bad && (len != '0);
    // Distance to the last key; never wraps since a4_key never exceeds KEY_LAST.
    last_key_c  = KEY_W'(KEY_LAST - a4_key) < KEY_STEP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      key       <= '0;
      a4_en     <= 1'b0;
      a4_key    <= KEY_START;
      len       <= '0;
      len_seen  <= 1'b0;
      bad       <= 1'b0;
    end else begin
      // Plaintext snoop; a write on the RUN exit edge still lands before CHECK.
      if (snoop_c) begin
        if (pt_addr == '0) begin
          len      <= pt_wrdata;
          len_seen <= 1'b1;
        end else if (!len_seen) begin
          bad <= 1'b1;
        end else if ((pt_addr <= len) && !printable_c) begin
          bad <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (en) begin
            state     <= LAUNCH;
            rdy       <= 1'b0;
            a4_en     <= 1'b1;
            a4_key    <= KEY_START;
            key       <= '0;
            key_valid <= 1'b0;
            len       <= '0;
            len_seen  <= 1'b0;
            bad       <= 1'b0;
          end
        end
        LAUNCH: begin
          if (!a4_rdy) begin
            state <= RUN;
            a4_en <= 1'b0;
          end
        end
        RUN: begin
          if (a4_rdy) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (pass_c) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key       <= a4_key;
            key_valid <= 1'b1;
          end else if (last_key_c) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key_valid <= 1'b0;
          end else begin
            state    <= LAUNCH;
            a4_en    <= 1'b1;
            a4_key   <= KEY_W'(a4_key + KEY_STEP);
            len      <= '0;
            len_seen <= 1'b0;
            bad      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
